// File: rtl/region_probe.sv
// Scans a SIZE x SIZE square of the frame buffer in raster order and reports
// whether any non-background pixel exists, how many, and where the first one is.
module region_probe #(
  parameter int         SIZE      = 21,
  parameter int         WIDTH     = 160,
  parameter int         HEIGHT    = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] coord,
  output logic        rd_en,
  output logic [7:0]  rd_x,
  output logic [6:0]  rd_y,
  input  logic [2:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [8:0]  hit_count,
  output logic [7:0]  first_x,
  output logic [6:0]  first_y
);
  localparam int CW = (SIZE > 1) ? $clog2(SIZE + 1) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      x0_q, x0_d;
  logic [6:0]      y0_q, y0_d;
  logic [CW-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic            p1_vld_q, p1_vld_d;
  logic [7:0]      p1_x_q, p1_x_d;
  logic [6:0]      p1_y_q, p1_y_d;
  logic            hit_q, hit_d;
  logic [8:0]      hit_count_q, hit_count_d;
  logic [7:0]      first_x_q, first_x_d;
  logic [6:0]      first_y_q, first_y_d;

  logic [8:0]      x_sum;
  logic [7:0]      y_sum;
  logic            slot_on, last_slot, px_hit;

  // Sums are one bit wider than the screen coordinates so wrap-around reads
  // as off-screen instead of aliasing to the left or top edge.
  always_comb begin
    x_sum     = {1'b0, x0_q} + 9'(cx_q);
    y_sum     = {1'b0, y0_q} + 8'(cy_q);
    slot_on   = (state_q == SCAN) && (x_sum < 9'(WIDTH)) && (y_sum < 8'(HEIGHT));
    last_slot = (cx_q == CW'(SIZE - 1)) && (cy_q == CW'(SIZE - 1));
    px_hit    = p1_vld_q && (rd_data != BG_COLOUR);
  end

  assign rd_en     = slot_on;
  assign rd_x      = (state_q == SCAN) ? x_sum[7:0] : 8'd0;
  assign rd_y      = (state_q == SCAN) ? y_sum[6:0] : 7'd0;
  assign busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign hit       = hit_q;
  assign hit_count = hit_count_q;
  assign first_x   = first_x_q;
  assign first_y   = first_y_q;

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    hit_d       = hit_q;
    hit_count_d = hit_count_q;
    first_x_d   = first_x_q;
    first_y_d   = first_y_q;
    // Slot coordinate rides alongside the read so the return can be attributed.
    p1_vld_d    = slot_on;
    p1_x_d      = x_sum[7:0];
    p1_y_d      = y_sum[6:0];

    if (px_hit) begin
      hit_d       = 1'b1;
      hit_count_d = hit_count_q + 9'd1;
      if (!hit_q) begin
        first_x_d = p1_x_q;
        first_y_d = p1_y_q;
      end
    end

    case (state_q)
      IDLE: if (start) begin
        x0_d        = coord[14:7];
        y0_d        = coord[6:0];
        cx_d        = '0;
        cy_d        = '0;
        hit_d       = 1'b0;
        hit_count_d = '0;
        first_x_d   = '0;
        first_y_d   = '0;
        state_d     = SCAN;
      end
      SCAN: begin
        if (cx_q == CW'(SIZE - 1)) begin
          cx_d = '0;
          cy_d = cy_q + CW'(1);
        end else begin
          cx_d = cx_q + CW'(1);
        end
        if (last_slot) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      p1_vld_q    <= 1'b0;
      p1_x_q      <= '0;
      p1_y_q      <= '0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
      first_x_q   <= '0;
      first_y_q   <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      p1_vld_q    <= p1_vld_d;
      p1_x_q      <= p1_x_d;
      p1_y_q      <= p1_y_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
      first_x_q   <= first_x_d;
      first_y_q   <= first_y_d;
    end
  end
endmodule
